monitor_verdict_sink: RTL
=========================

// Module: monitor_verdict_sink
// PURPOSE
// - Receiving end of the monitor's output-stream interface: samples output_N / output_N_aktv each cycle and timestamps every active cycle.
// - Buffers the resulting records and serializes them as valid/ready beats toward host readout (UART/AXIS bridge).
// - Replaces ad-hoc $display collection with synthesizable capture.
// PARAMETERS
// - NUM_OUT  2   number of monitor output streams
// - DATA_W   64  width of each output value and of every serialized beat
// - TS_W     32  cycle-timestamp width; TS_W+NUM_OUT <= DATA_W
// - DEPTH    16  record FIFO depth, power of two
// PORTS
// - clk          in   1               system clock
// - rst          in   1               synchronous, active-high reset
// - en           in   1               monitor enable; same signal that drives the monitor
// - out_value    in   NUM_OUT*DATA_W  signed output_N values; stream i at bits [i*DATA_W +: DATA_W]
// - out_aktv     in   NUM_OUT         output_N_aktv flags; bit i belongs to stream i
// - m_valid      out  1               beat valid
// - m_ready      in   1               beat accepted by consumer
// - m_data       out  DATA_W          beat payload
// - m_hdr        out  1               beat is a record header
// - m_last       out  1               final beat of the record
// - drop_cnt     out  16              saturating count of dropped records
// - overflow     out  1               sticky; set on the first drop
// BEHAVIOUR
// - Reset: m_valid, m_hdr, m_last, overflow = 0; drop_cnt = 0; ts = 0; FIFO empty; FSM IDLE. Mid-record reset discards the record; m_valid is 0 in the next cycle.
// - Timestamp: ts += 1 (mod 2^TS_W) on every en=1 cycle; ts holds when en=0. A record carries the ts value sampled in the capture cycle.
// - Capture: on a cycle with en=1 and |out_aktv, push {ts, out_aktv, out_value} into the FIFO.
//   - Push is accepted when !full, or when full and a pop happens in the same cycle.
//   - Otherwise the record is dropped: drop_cnt += 1 (saturates at 0xFFFF) and overflow is set.
//   - en=0 or out_aktv=0 never pushes.
// - Latency: m_valid for the header rises exactly 1 cycle after the capture edge when FIFO and FSM are idle.
// - Beat format:
//   - Header: m_data = {zero-pad, mask[NUM_OUT-1:0], ts[TS_W-1:0]}, with m_hdr=1.
//   - Data beats: one per set mask bit, in ascending stream index; m_data = that stream's value.
//   - m_last=1 on the final data beat. A header is never last, because mask != 0.
// - Handshake: a beat transfers when m_valid && m_ready. While m_valid=1 and m_ready=0, m_data, m_hdr and m_last hold stable and m_valid stays 1.
// - FSM:
//   - IDLE -> HDR when the FIFO is non-empty.
//   - HDR -> DATA on accept; the index moves to the lowest set bit.
//   - DATA -> DATA on accept of a non-last beat; the index moves to the next set bit.
//   - DATA (last) accept: pop the FIFO; go to HDR if another record is present, else IDLE. No bubble between records.
// - Draining continues while en=0. Capture and drain run concurrently; a full FIFO plus a same-cycle pop admits the push.
// STRUCTURE
// - Package monitor_sink_pkg:
//   - state enum IDLE/HDR/DATA;
//   - record width constant REC_W = TS_W+NUM_OUT+NUM_OUT*DATA_W;
//   - function next_set_idx(mask, idx).
// - Sub-module sync_fifo (WIDTH=REC_W, DEPTH): registered, with full/empty flags and simultaneous push/pop.
// - Top level contains the ts counter, capture/drop logic and the serializer FSM.
// TESTING
// - Single event: NUM_OUT=2, aktv=2'b01, value0=5 at ts=10, m_ready=1.
//   -> beat 1: hdr {mask=01, ts=10}; beat 2: 5 with last=1. Header appears 1 cycle after capture.
// - Both active: aktv=2'b11, values (-3, 7).
//   -> hdr mask=11; then 0xFFFF_FFFF_FFFF_FFFD; then 7 with last=1.
// - Sparse mask: aktv=2'b10, value1=42.
//   -> hdr mask=10; one data beat 42 with last=1; stream 0 is never emitted.
// - Backpressure: m_ready=0 for 20 cycles, with 17 consecutive active cycles.
//   -> 16 records buffered; drop_cnt=1, overflow=1. Beats stay stable while stalled; on release, 16 records drain in ts order.
// - en gating: en=0 for 50 cycles with aktv=1.
//   -> no pushes, ts frozen; after en=1 the next record's ts is the pre-gate ts+1.
// - Mid-record reset: assert rst after the header is accepted and before the data beat.
//   -> m_valid=0 the next cycle; drop_cnt=0, FIFO empty, ts restarts at 0.

Source files
------------

// File: rtl/monitor_sink_pkg.sv
// rtl/monitor_sink_pkg.sv - shared types, sizes and mask helper for the verdict sink
package monitor_sink_pkg;

  localparam int DEF_NUM_OUT = 2;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TS_W    = 32;
  localparam int DEF_DEPTH   = 16;
  localparam int REC_W       = DEF_TS_W + DEF_NUM_OUT + DEF_NUM_OUT * DEF_DATA_W;
  localparam int MASK_MAX    = 32;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  // Lowest set bit strictly above idx; -1 when none remains (idx=-1 yields the lowest).
  function automatic int next_set_idx(input logic [MASK_MAX-1:0] mask, input int idx);
    int r;
    r = -1;
    for (int i = MASK_MAX - 1; i >= 0; i--) begin
      if (i > idx && mask[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - registered record FIFO with full/empty and same-cycle push/pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             wr_en, rd_en;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem[rd_ptr];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/monitor_verdict_sink.sv
// rtl/monitor_verdict_sink.sv - timestamps active monitor outputs and serializes them as header/data beats
module monitor_verdict_sink
  import monitor_sink_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TS_W    = DEF_TS_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_OUT*DATA_W-1:0] out_value,
  input  logic [NUM_OUT-1:0]        out_aktv,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_W-1:0]         m_data,
  output logic                      m_hdr,
  output logic                      m_last,
  output logic [15:0]               drop_cnt,
  output logic                      overflow
);

  localparam int RW    = TS_W + NUM_OUT + NUM_OUT * DATA_W;
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]           ts_q;
  logic                      push_req, push, pop, drop;
  logic                      full, empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [RW-1:0]             head;
  logic [TS_W-1:0]           head_ts;
  logic [NUM_OUT-1:0]        head_mask;
  logic [NUM_OUT*DATA_W-1:0] head_vals;
  logic [MASK_MAX-1:0]       mask_ext;
  int                        first_idx, nxt_idx;
  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;

  assign push_req = en && (|out_aktv);
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q     <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (en) ts_q <= ts_q + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  sync_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({ts_q, out_aktv, out_value}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign head_ts   = head[RW-1 -: TS_W];
  assign head_mask = head[NUM_OUT*DATA_W +: NUM_OUT];
  assign head_vals = head[NUM_OUT*DATA_W-1:0];
  assign mask_ext  = MASK_MAX'(head_mask);
  assign first_idx = next_set_idx(mask_ext, -1);
  assign nxt_idx   = next_set_idx(mask_ext, int'(idx_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // IDLE presents the header combinationally so it appears the cycle after capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    m_valid = 1'b0;
    m_hdr   = 1'b0;
    m_last  = 1'b0;
    m_data  = '0;
    pop     = 1'b0;
    case (state_q)
      IDLE, HDR: begin
        if (!empty) begin
          m_valid = 1'b1;
          m_hdr   = 1'b1;
          m_data  = DATA_W'({head_mask, head_ts});
          if (m_ready) begin
            state_d = DATA;
            idx_d   = IDX_W'(first_idx);
          end else begin
            state_d = HDR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        m_valid = 1'b1;
        m_data  = head_vals[int'(idx_q)*DATA_W +: DATA_W];
        m_last  = (nxt_idx < 0);
        if (m_ready) begin
          if (nxt_idx < 0) begin
            pop     = 1'b1;
            state_d = (fifo_count > CNT_W'(1) || push) ? HDR : IDLE;
          end else begin
            idx_d = IDX_W'(nxt_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
